// File: rtl/mem_responder.sv
// mem_responder: single-port scratchpad serving the imem and dmem request
// ports. One access per cycle, dmem-priority arbitration with an imem
// starvation guard, byte-masked writes, and in-order responses after a fixed
// LATENCY through a shift-register response pipeline.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_req_valid,
    input  logic [31:0] imem_req_addr,
    output logic        imem_req_ready,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_data,
    output logic        imem_resp_err,

    input  logic        dmem_req_valid,
    input  logic [31:0] dmem_req_addr,
    input  logic        dmem_req_wen,
    input  logic [3:0]  dmem_req_wmask,
    input  logic [31:0] dmem_req_wdata,
    output logic        dmem_req_ready,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_e;

    typedef struct packed {
        logic        valid;
        port_e       port;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam int unsigned PIPE_W = LATENCY * $bits(resp_t);

    logic [31:0]           mem [DEPTH_WORDS];
    logic [SW-1:0]         starve_cnt;
    logic                  imem_force;

    logic                  acc_valid;
    port_e                 acc_port;
    logic [31:0]           acc_addr;
    logic                  acc_wen;
    logic [3:0]            acc_wmask;
    logic [31:0]           acc_wdata;
    logic                  acc_err;
    logic [AW-1:0]         acc_idx;
    logic                  acc_rd;
    logic [1:0]            unused_addr_lsbs;

    resp_t [LATENCY-1:0]   pipe;
    resp_t                 resp_out;

    // Arbitration: dmem wins contention unless imem has lost STARVE_LIMIT times
    always_comb begin
        imem_force     = (starve_cnt == STARVE_MAX);
        imem_req_ready = 1'b0;
        dmem_req_ready = 1'b0;
        if (!rst) begin
            imem_req_ready = imem_req_valid && (!dmem_req_valid || imem_force);
            dmem_req_ready = dmem_req_valid && !(imem_req_valid && imem_force);
        end
    end

    // Select the accepted request and decode its word index / range
    always_comb begin
        acc_valid = imem_req_ready || dmem_req_ready;
        if (dmem_req_ready) begin
            acc_port = PORT_DMEM;
            acc_addr = dmem_req_addr;
            acc_wen  = dmem_req_wen;
        end else begin
            acc_port = PORT_IMEM;
            acc_addr = imem_req_addr;
            acc_wen  = 1'b0;
        end
        acc_wmask        = dmem_req_wmask;
        acc_wdata        = dmem_req_wdata;
        acc_idx          = acc_addr[AW+1:2];
        acc_err          = |acc_addr[31:AW+2];
        acc_rd           = acc_valid && !acc_wen && !acc_err;
        unused_addr_lsbs = acc_addr[1:0];
    end

    // Count consecutive cycles imem is left waiting, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!imem_req_valid || imem_req_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Byte-masked write; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (acc_valid && acc_wen && !acc_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response shift register: stage 0 takes the new access (registered array
    // read), higher stages age by one each cycle; the top entry falls off.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe <= PIPE_W'({pipe,
                             acc_valid,
                             acc_port,
                             acc_valid && acc_err,
                             acc_rd ? mem[acc_idx] : 32'd0});
        end
    end

    // Demultiplex the oldest stage onto its port; idle ports drive zeros and
    // anything still in flight while rst is high is suppressed.
    always_comb begin
        resp_out = pipe[LATENCY-1];
        if (rst) begin
            resp_out = '0;
        end
        imem_resp_valid = resp_out.valid && (resp_out.port == PORT_IMEM);
        dmem_resp_valid = resp_out.valid && (resp_out.port == PORT_DMEM);
        imem_resp_err   = imem_resp_valid && resp_out.err;
        dmem_resp_err   = dmem_resp_valid && resp_out.err;
        imem_resp_data  = imem_resp_valid ? resp_out.data : '0;
        dmem_resp_data  = dmem_resp_valid ? resp_out.data : '0;
    end

endmodule
